// File: rtl/seq_detector_param.sv
// Serial detector for a run-time programmable LEN-bit pattern, with
// overlapping/non-overlapping modes, sample qualifier and saturating match counter.
module seq_detector_param #(
    parameter int             LEN     = 3,
    parameter logic [LEN-1:0] PAT_RST = 3'b100,
    parameter int             CNT_W   = 8,
    localparam int            FILL_W  = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              en,
    input  logic              x1,
    input  logic              pat_load,
    input  logic [LEN-1:0]    pat_in,
    input  logic              overlap,
    input  logic              cnt_clr,
    output logic              z,
    output logic [FILL_W-1:0] fill,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat
);

    logic [LEN-1:0]    pat_r;
    logic [LEN-1:0]    hist_r;
    logic [FILL_W-1:0] fill_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              z_r;

    logic [LEN-1:0]    hist_n_s;
    logic [FILL_W-1:0] fill_n_s;
    logic              hit_s;
    logic              sat_s;

    // Next history/fill and match decision for an accepted sample
    always_comb begin
        hist_n_s = {hist_r[LEN-2:0], x1};
        if (fill_r == FILL_W'(LEN)) begin
            fill_n_s = fill_r;
        end else begin
            fill_n_s = fill_r + FILL_W'(1);
        end
        // Fill gating keeps the zeroed history from matching an all-zeros pattern
        hit_s = en && !pat_load && (fill_n_s == FILL_W'(LEN)) && (hist_n_s == pat_r);
        sat_s = (cnt_r == {CNT_W{1'b1}});
    end

    // Pattern, history, fill, match pulse and counter state
    always_ff @(posedge clk) begin
        if (!nreset) begin
            pat_r  <= PAT_RST;
            hist_r <= {LEN{1'b0}};
            fill_r <= {FILL_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            z_r    <= 1'b0;
        end else begin
            if (pat_load) begin
                pat_r  <= pat_in;
                hist_r <= {LEN{1'b0}};
                fill_r <= {FILL_W{1'b0}};
                z_r    <= 1'b0;
            end else if (en) begin
                hist_r <= hist_n_s;
                z_r    <= hit_s;
                if (hit_s && !overlap) begin
                    fill_r <= {FILL_W{1'b0}};
                end else begin
                    fill_r <= fill_n_s;
                end
            end else begin
                z_r <= 1'b0;
            end

            if (cnt_clr) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (hit_s && !sat_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign z         = z_r;
    assign fill      = fill_r;
    assign match_cnt = cnt_r;
    assign cnt_sat   = sat_s;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param: a default LEN=3 instance
// and a LEN=2/CNT_W=2 instance for counter saturation.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       nreset;
    logic       en, x1, pat_load, overlap, cnt_clr;
    logic [2:0] pat_in;
    logic       z;
    logic [1:0] fill;
    logic [7:0] match_cnt;
    logic       cnt_sat;

    logic       en_b, x1_b;
    logic       z_b;
    logic [1:0] fill_b;
    logic [1:0] cnt_b;
    logic       sat_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .nreset(nreset), .en(en), .x1(x1), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr),
        .z(z), .fill(fill), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detector_param #(.LEN(2), .PAT_RST(2'b11), .CNT_W(2)) dut_b (
        .clk(clk), .nreset(nreset), .en(en_b), .x1(x1_b), .pat_load(1'b0),
        .pat_in(2'b00), .overlap(1'b1), .cnt_clr(1'b0),
        .z(z_b), .fill(fill_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    task automatic step(input logic e, input logic x);
        en = e; x1 = x;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0; en = 1'b0; x1 = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
        en_b = 1'b0; x1_b = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
    endtask

    task automatic do_load(input logic [2:0] p);
        pat_load = 1'b1; pat_in = p; en = 1'b0;
        @(posedge clk); #1;
        pat_load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (z !== 1'b0)       begin bad++; $display("FAIL reset_z got=%b exp=0", z); end
        total++; if (fill !== 2'd0)    begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill); end
        total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt); end
        total++; if (cnt_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", cnt_sat); end
        total++; if (cnt_b !== 2'd0)   begin bad++; $display("FAIL reset_cnt_b got=%0d exp=0", cnt_b); end
    endtask

    task automatic test_legacy();
        logic [6:0] xs    = 7'b1001000;
        logic [6:0] exp_z = 7'b0010010;
        logic [1:0] exp_f [7] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        do_reset();
        overlap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, xs[6-i]);
            total++; if (z !== exp_z[6-i]) begin bad++; $display("FAIL legacy_z[%0d] got=%b exp=%b", i, z, exp_z[6-i]); end
            total++; if (fill !== exp_f[i]) begin bad++; $display("FAIL legacy_fill[%0d] got=%0d exp=%0d", i, fill, exp_f[i]); end
        end
        total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL legacy_cnt got=%0d exp=2", match_cnt); end
    endtask

    task automatic test_overlap(input logic ov, input logic [4:0] exp_z, input logic [7:0] exp_cnt);
        logic [4:0] xs = 5'b10101;
        do_reset();
        do_load(3'b101);
        overlap = ov;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, xs[4-i]);
            total++; if (z !== exp_z[4-i]) begin bad++; $display("FAIL overlap%0b_z[%0d] got=%b exp=%b", ov, i, z, exp_z[4-i]); end
        end
        total++; if (match_cnt !== exp_cnt) begin bad++; $display("FAIL overlap%0b_cnt got=%0d exp=%0d", ov, match_cnt, exp_cnt); end
    endtask

    task automatic test_en_gap();
        do_reset();
        overlap = 1'b0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            total++; if (z !== 1'b0 || fill !== 2'd1) begin bad++; $display("FAIL gap_hold[%0d] got z=%b fill=%0d exp z=0 fill=1", i, z, fill); end
        end
        step(1'b1, 1'b0);
        total++; if (z !== 1'b0) begin bad++; $display("FAIL gap_z_mid got=%b exp=0", z); end
        step(1'b1, 1'b0);
        total++; if (z !== 1'b1) begin bad++; $display("FAIL gap_z_hit got=%b exp=1", z); end
        total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL gap_cnt got=%0d exp=1", match_cnt); end

        do_reset();
        step(1'b1, 1'b1);
        do_load(3'b100);
        total++; if (fill !== 2'd0) begin bad++; $display("FAIL load_fill got=%0d exp=0", fill); end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        total++; if (z !== 1'b0) begin bad++; $display("FAIL load_flush_z got=%b exp=0", z); end
        total++; if (fill !== 2'd2) begin bad++; $display("FAIL load_flush_fill got=%0d exp=2", fill); end
    endtask

    task automatic test_zero_pat();
        do_reset();
        do_load(3'b000);
        overlap = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        total++; if (z !== 1'b0) begin bad++; $display("FAIL zero_z_early got=%b exp=0", z); end
        total++; if (fill !== 2'd2) begin bad++; $display("FAIL zero_fill got=%0d exp=2", fill); end
        step(1'b1, 1'b0);
        total++; if (z !== 1'b1) begin bad++; $display("FAIL zero_z_hit got=%b exp=1", z); end
    endtask

    task automatic test_load_collision();
        do_reset();
        overlap = 1'b0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        pat_load = 1'b1; pat_in = 3'b100; en = 1'b1; x1 = 1'b0;
        @(posedge clk); #1;
        pat_load = 1'b0;
        total++; if (z !== 1'b0 || match_cnt !== 8'd0 || fill !== 2'd0)
            begin bad++; $display("FAIL load_collision got z=%b cnt=%0d fill=%0d exp 0/0/0", z, match_cnt, fill); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_c [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [5:0] exp_z = 6'b011111;
        logic [5:0] exp_s = 6'b000111;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            en_b = 1'b1; x1_b = 1'b1;
            @(posedge clk); #1;
            total++; if (z_b !== exp_z[5-i]) begin bad++; $display("FAIL sat_z[%0d] got=%b exp=%b", i, z_b, exp_z[5-i]); end
            total++; if (cnt_b !== exp_c[i]) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, cnt_b, exp_c[i]); end
            total++; if (sat_b !== exp_s[5-i]) begin bad++; $display("FAIL sat_flag[%0d] got=%b exp=%b", i, sat_b, exp_s[5-i]); end
        end
        en_b = 1'b0;
    endtask

    task automatic test_cnt_clr();
        do_reset();
        overlap = 1'b0;
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
        total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL clr_pre_cnt got=%0d exp=1", match_cnt); end
        step(1'b1, 1'b1); step(1'b1, 1'b0);
        cnt_clr = 1'b1;
        step(1'b1, 1'b0);
        cnt_clr = 1'b0;
        total++; if (z !== 1'b1) begin bad++; $display("FAIL clr_z got=%b exp=1", z); end
        total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", match_cnt); end

        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
        total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL clr_recount got=%0d exp=1", match_cnt); end
        step(1'b1, 1'b1); step(1'b1, 1'b0);
        nreset = 1'b0; en = 1'b1; x1 = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
        total++; if (z !== 1'b0 || fill !== 2'd0 || match_cnt !== 8'd0 || cnt_sat !== 1'b0)
            begin bad++; $display("FAIL midreset got z=%b fill=%0d cnt=%0d sat=%b exp all 0", z, fill, match_cnt, cnt_sat); end
        step(1'b1, 1'b0);
        total++; if (z !== 1'b0 || fill !== 2'd1) begin bad++; $display("FAIL postreset got z=%b fill=%0d exp z=0 fill=1", z, fill); end
    endtask

    initial begin
        nreset = 1'b0; en = 1'b0; x1 = 1'b0; pat_load = 1'b0; pat_in = 3'b000;
        overlap = 1'b0; cnt_clr = 1'b0; en_b = 1'b0; x1_b = 1'b0;
        test_reset();
        test_legacy();
        test_overlap(1'b1, 5'b00101, 8'd2);
        test_overlap(1'b0, 5'b00100, 8'd1);
        test_en_gap();
        test_zero_pat();
        test_load_collision();
        test_back_to_back();
        test_cnt_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector, the successor of the fixed "1-0-0" detector FSM. It matches a run-time programmable pattern of LEN bits on a serial input, with selectable overlapping or non-overlapping detection, a sample-enable qualifier, and a saturating match counter. It sits between the serial front end and the control logic that consumes match pulses. Reset defaults reproduce the legacy "100" detector behaviour.

## Interface
- LEN, 3, pattern length in bits; legal range 2..16
- PAT_RST, 3'b100 (LEN bits), pattern loaded at reset; bit LEN-1 is the first bit received
- CNT_W, 8, match counter width
- clk  input  1  clock, all state updates on the rising edge
- nreset  input  1  reset, synchronous, active-low
- en  input  1  sample qualifier; x1 is consumed only on edges where en=1
- x1  input  1  serial data bit
- pat_load  input  1  load pat_in as the new pattern; flushes history
- pat_in  input  LEN  new pattern, MSB is the first bit received
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  input  1  clear match counter
- z  output  1  registered match pulse
- fill  output  clog2(LEN+1)  number of valid history bits, saturates at LEN
- match_cnt  output  CNT_W  number of matches, saturating
- cnt_sat  output  1  match_cnt is all-ones

## Operation
- State: pattern register pat, history shift register hist[LEN-1:0], fill counter, match_cnt, registered z.
- Priority per edge: nreset > pat_load > en-sample. cnt_clr is evaluated independently of pat_load.
- nreset=0: pat<=PAT_RST, hist<=0, fill<=0, match_cnt<=0, z<=0. cnt_sat therefore reads 0.
- pat_load=1 (nreset=1): pat<=pat_in, hist<=0, fill<=0, z<=0. x1 is not sampled on that edge, even if en=1. match_cnt is retained.
- en=1 (no load):
  - hist_n = {hist[LEN-2:0], x1}
  - fill_n = min(fill+1, LEN)
  - hit = (fill_n==LEN) && (hist_n==pat)
  - hist<=hist_n, z<=hit
  - overlap=1, or hit=0: fill<=fill_n
  - overlap=0 and hit=1: fill<=0, so the next match needs LEN fresh bits
- en=0: hist, fill and match_cnt hold; z<=0.
- Counter:
  - cnt_clr=1: match_cnt<=0; clear wins over a simultaneous hit.
  - Otherwise, hit and match_cnt is not all-ones: match_cnt increments.
  - At all-ones it holds.
- cnt_sat is combinational: match_cnt=={CNT_W{1'b1}}.
- The pattern may equal any LEN-bit value, including all-zeros and all-ones. The fill gating prevents false matches on the zeroed history after reset or load.

## Timing
- Latency: z is high for exactly one cycle, in the cycle after the edge that sampled the completing bit. match_cnt updates on the same edge that sets z.
- Back-to-back hits are possible in overlap mode. Example: pattern 11, input 1,1,1 gives z high on consecutive cycles.
- Non-overlap minimum spacing between hits is LEN accepted samples.
- Reset, or pat_load, applied mid-sequence discards the partial history. No match can occur until LEN further samples are accepted.
- Gaps with en=0 do not break a sequence. Only accepted samples count.
- pat_load and a completing bit on the same edge: the load wins, and no hit is recorded.
- Changing overlap takes effect on the next accepted sample. It does not alter the current fill.

## Test plan
- Reset defaults, en=1, x1 stream 1,0,0,1,0,0,0 -> z pulses the cycle after the 3rd and 6th samples only; match_cnt=2; fill resets to 0 after each hit when overlap=0.
- Overlap: pat_load with pat_in=3'b101, overlap=1, stream 1,0,1,0,1 -> z after samples 3 and 5, match_cnt=2. The same stream with overlap=0 -> z after sample 3 only, match_cnt=1.
- en gaps and load: pattern 100, stream 1,(en=0 x3),0,0 -> one hit. Asserting pat_load between the 1 and the first 0 -> no hit, and fill=0 after the load.
- All-zeros pattern: pat_load with 3'b000 immediately after reset, stream 0,0 -> no hit, fill=2. A third 0 -> hit.
- Saturation: CNT_W=2, overlap=1, pattern 11, stream of six 1s -> match_cnt goes 1,2,3,3,3; cnt_sat=1 from the third hit on.
- Counter clear: cnt_clr asserted on the same edge as a hit -> z=1 and match_cnt=0. A synchronous reset mid-sequence after inputs 1,0 -> all outputs 0, and the next 0 does not produce z.
